// File: rtl/m_ext_muldiv_iter_pkg.sv
// Shared M-extension decode types, opcode constants and helpers.
package m_ext_muldiv_iter_pkg;

    localparam logic [6:0] OPCODE_OP = 7'b0110011;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } func3_t;

    typedef enum logic [6:0] {
        BASE   = 7'b0000000,
        MULDIV = 7'b0000001,
        ALT    = 7'b0100000
    } func7_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    // Which operands are interpreted as two's complement.
    typedef enum logic [1:0] {
        SIGN_NONE = 2'd0,
        SIGN_RS1  = 2'd1,
        SIGN_BOTH = 2'd2
    } op_sign_t;

    function automatic func3_t get_func3(input logic [31:0] insn);
        return func3_t'(insn[14:12]);
    endfunction

    function automatic func7_t get_func7(input logic [31:0] insn);
        return func7_t'(insn[31:25]);
    endfunction

    function automatic op_sign_t sign_mode(input func3_t f3);
        case (f3)
            MULH, DIV, REM: return SIGN_BOTH;
            MULHSU:         return SIGN_RS1;
            default:        return SIGN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/m_ext_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
module m_ext_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            dividend_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            quo_bit
);

    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    // Remainder is always below the divisor, so the shifted trial fits XLEN+1 bits
    // and the top bit of the difference is a clean borrow flag.
    always_comb begin
        trial   = {rem_in, dividend_bit};
        diff    = trial - {1'b0, divisor};
        quo_bit = ~diff[XLEN];
        rem_out = quo_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];
    end

endmodule

// File: rtl/m_ext_muldiv_iter.sv
// Iterative PCPI multiply/divide unit: UNROLL bits per cycle, special divide cases in one cycle.
module m_ext_muldiv_iter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned UNROLL     = 1,
    parameter int unsigned ENABLE_DIV = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            pcpi_valid,
    input  logic [31:0]     pcpi_insn,
    input  logic [XLEN-1:0] pcpi_rs1,
    input  logic [XLEN-1:0] pcpi_rs2,
    output logic            pcpi_wr,
    output logic [XLEN-1:0] pcpi_rd,
    output logic            pcpi_wait,
    output logic            pcpi_ready
);
    import m_ext_muldiv_iter_pkg::*;

    localparam int unsigned     STEPS    = XLEN / UNROLL;
    localparam int unsigned     CNT_W    = $clog2(STEPS) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS - 1);
    localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t     state;
    func3_t            func3_q;
    logic              neg_q;
    logic              holdoff;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   operand;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc;         // {hi, lo}: product, or {remainder, dividend/quotient}

    // Decode and operand conditioning
    func3_t          f3;
    op_sign_t        smode;
    logic            is_div_c;
    logic            is_rem_c;
    logic            s1;
    logic            s2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            neg_c;
    logic            claim;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_rd;

    logic unused_insn;
    assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    // Claim decision, operand magnitudes and one-cycle special-case results
    always_comb begin
        f3       = get_func3(pcpi_insn);
        smode    = sign_mode(f3);
        is_div_c = pcpi_insn[14];
        is_rem_c = pcpi_insn[13];
        s1       = (smode != SIGN_NONE) && pcpi_rs1[XLEN-1];
        s2       = (smode == SIGN_BOTH) && pcpi_rs2[XLEN-1];
        mag1     = s1 ? -pcpi_rs1 : pcpi_rs1;
        mag2     = s2 ? -pcpi_rs2 : pcpi_rs2;
        neg_c    = (is_div_c && is_rem_c) ? s1 : (s1 ^ s2);
        claim    = pcpi_valid
                   && (pcpi_insn[6:0] == OPCODE_OP)
                   && (get_func7(pcpi_insn) == MULDIV)
                   && ((ENABLE_DIV != 0) || !is_div_c)
                   && (state == IDLE)
                   && !holdoff;
        div_zero = (pcpi_rs2 == '0);
        div_ovf  = ((f3 == DIV) || (f3 == REM)) && (pcpi_rs1 == XMIN) && (pcpi_rs2 == '1);
        special  = is_div_c && (div_zero || div_ovf);
        if (div_zero) begin
            special_rd = is_rem_c ? pcpi_rs1 : '1;
        end else begin
            special_rd = is_rem_c ? '0 : pcpi_rs1;
        end
    end

    // Multiply: UNROLL shift-add steps on the {hi, lo} accumulator
    logic [2*XLEN-1:0] mul_acc;
    logic [XLEN:0]     mul_sum;

    always_comb begin
        mul_acc = acc;
        mul_sum = '0;
        for (int i = 0; i < int'(UNROLL); i++) begin
            mul_sum = {1'b0, mul_acc[2*XLEN-1:XLEN]} + (mul_acc[0] ? {1'b0, operand} : '0);
            mul_acc = {mul_sum, mul_acc[XLEN-1:1]};
        end
    end

    // Divide: chain of UNROLL restoring steps
    logic [XLEN-1:0] rem_chain [UNROLL+1];
    logic [XLEN-1:0] quo_chain [UNROLL+1];

    assign rem_chain[0] = acc[2*XLEN-1:XLEN];
    assign quo_chain[0] = acc[XLEN-1:0];

    for (genvar g = 0; g < UNROLL; g++) begin : g_div
        logic qb;
        m_ext_div_step #(.XLEN(XLEN)) u_step (
            .rem_in       (rem_chain[g]),
            .dividend_bit (quo_chain[g][XLEN-1]),
            .divisor      (operand),
            .rem_out      (rem_chain[g+1]),
            .quo_bit      (qb)
        );
        assign quo_chain[g+1] = {quo_chain[g][XLEN-2:0], qb};
    end

    // Next accumulator value and the final signed result derived from it
    logic [2:0]        f3q_bits;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   result;

    always_comb begin
        f3q_bits = func3_q;
        acc_step = f3q_bits[2] ? {rem_chain[UNROLL], quo_chain[UNROLL]} : mul_acc;
        prod     = neg_q ? -acc_step : acc_step;
        quo      = acc_step[XLEN-1:0];
        rem      = acc_step[2*XLEN-1:XLEN];
        case (func3_q)
            MUL:                 result = prod[XLEN-1:0];
            MULH, MULHSU, MULHU: result = prod[2*XLEN-1:XLEN];
            DIV, DIVU:           result = neg_q ? -quo : quo;
            default:             result = neg_q ? -rem : rem;
        endcase
    end

    // Control FSM with registered PCPI handshake outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            func3_q    <= MUL;
            neg_q      <= 1'b0;
            holdoff    <= 1'b0;
            cnt        <= '0;
            operand    <= '0;
            acc        <= '0;
            pcpi_wr    <= 1'b0;
            pcpi_rd    <= '0;
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b0;
        end else begin
            pcpi_wr    <= 1'b0;
            pcpi_ready <= 1'b0;
            holdoff    <= 1'b0;
            case (state)
                IDLE: begin
                    if (claim) begin
                        func3_q   <= f3;
                        neg_q     <= neg_c;
                        pcpi_wait <= 1'b1;
                        if (special) begin
                            state      <= DONE;
                            pcpi_rd    <= special_rd;
                            pcpi_ready <= 1'b1;
                            pcpi_wr    <= 1'b1;
                        end else begin
                            state   <= CALC;
                            cnt     <= CNT_LOAD;
                            operand <= is_div_c ? mag2 : mag1;
                            acc     <= {{XLEN{1'b0}}, (is_div_c ? mag1 : mag2)};
                        end
                    end
                end
                CALC: begin
                    if (!pcpi_valid) begin
                        state     <= IDLE;
                        pcpi_wait <= 1'b0;
                    end else begin
                        acc <= acc_step;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == '0) begin
                            state      <= DONE;
                            pcpi_rd    <= result;
                            pcpi_ready <= 1'b1;
                            pcpi_wr    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // The finished instruction's valid may still be high next cycle
                    state     <= IDLE;
                    pcpi_wait <= 1'b0;
                    holdoff   <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    pcpi_wait <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_ext_muldiv_iter.sv
// Scoreboard bench for m_ext_muldiv_iter: default, UNROLL=4 and no-divide instances.
module tb_m_ext_muldiv_iter;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        valid  = 1'b0;
    int          sel    = 0;
    logic [31:0] insn   = '0;
    logic [31:0] rs1    = '0;
    logic [31:0] rs2    = '0;

    logic        v0, v1, v2;
    logic        wr0, wr1, wr2;
    logic        wait0, wait1, wait2;
    logic        rdy0, rdy1, rdy2;
    logic [31:0] rd0, rd1, rd2;

    logic        wr_o, wait_o, rdy_o;
    logic [31:0] rd_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    assign v0 = valid && (sel == 0);
    assign v1 = valid && (sel == 1);
    assign v2 = valid && (sel == 2);

    m_ext_muldiv_iter #(.XLEN(32), .UNROLL(1), .ENABLE_DIV(1)) dut (
        .clk(clk), .resetn(resetn), .pcpi_valid(v0), .pcpi_insn(insn),
        .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr0), .pcpi_rd(rd0),
        .pcpi_wait(wait0), .pcpi_ready(rdy0));

    m_ext_muldiv_iter #(.XLEN(32), .UNROLL(4), .ENABLE_DIV(1)) dut_u4 (
        .clk(clk), .resetn(resetn), .pcpi_valid(v1), .pcpi_insn(insn),
        .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr1), .pcpi_rd(rd1),
        .pcpi_wait(wait1), .pcpi_ready(rdy1));

    m_ext_muldiv_iter #(.XLEN(32), .UNROLL(1), .ENABLE_DIV(0)) dut_nd (
        .clk(clk), .resetn(resetn), .pcpi_valid(v2), .pcpi_insn(insn),
        .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr2), .pcpi_rd(rd2),
        .pcpi_wait(wait2), .pcpi_ready(rdy2));

    // Observe whichever instance is currently being driven
    always_comb begin
        case (sel)
            1:       begin wr_o = wr1; wait_o = wait1; rdy_o = rdy1; rd_o = rd1; end
            2:       begin wr_o = wr2; wait_o = wait2; rdy_o = rdy2; rd_o = rd2; end
            default: begin wr_o = wr0; wait_o = wait0; rdy_o = rdy0; rd_o = rd0; end
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // Issue one instruction, hold valid until ready, score the result and its latency
    task automatic run_op(input string tag, input logic [31:0] i, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_rd,
                          input int exp_cyc, input bit hold);
        int cyc;
        int busy;
        int quiet;
        bit seen;
        cyc = 0; busy = 0; quiet = 0; seen = 1'b0;
        @(negedge clk);
        insn = i; rs1 = a; rs2 = b; valid = 1'b1;
        exp_q.push_back(exp_rd);
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (wait_o) busy++;
            if (rdy_o) begin
                seen = 1'b1;
                check_eq({tag, ":wr"}, 64'(wr_o), 64'(1));
                check_eq({tag, ":cycle"}, 64'(cyc), 64'(exp_cyc));
                check_eq({tag, ":rd"}, 64'(rd_o), 64'(exp_q.pop_front()));
            end
        end
        check_eq({tag, ":ready_seen"}, 64'(seen), 64'(1));
        if (!seen) exp_q.delete();
        check_eq({tag, ":wait_cycles"}, 64'(busy), 64'(exp_cyc));
        if (hold) begin
            @(negedge clk);
            if (wait_o || rdy_o) quiet++;
        end
        valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (wait_o || rdy_o) quiet++;
        end
        check_eq({tag, ":quiet"}, 64'(quiet), 64'(0));
    endtask

    // Present an instruction the unit must not claim
    task automatic no_claim(input string tag, input logic [31:0] i);
        int busy;
        busy = 0;
        @(negedge clk);
        insn = i; rs1 = 32'd5; rs2 = 32'd1; valid = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (wait_o || rdy_o || wr_o) busy++;
        end
        valid = 1'b0;
        check_eq({tag, ":busy"}, 64'(busy), 64'(0));
    endtask

    localparam logic [6:0] F7M = 7'b0000001;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;

        repeat (2) @(negedge clk);
        check_eq("rst:wait", 64'(wait_o), 64'(0));
        check_eq("rst:ready", 64'(rdy_o), 64'(0));
        check_eq("rst:wr", 64'(wr_o), 64'(0));
        check_eq("rst:rd", 64'(rd_o), 64'(0));
        resetn = 1'b1;

        sel = 0;
        run_op("mul", mk(F7M, 3'b000), 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0);
        run_op("mulh", mk(F7M, 3'b001), 32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0);
        run_op("mulhu", mk(F7M, 3'b011), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b1);
        run_op("mulhsu", mk(F7M, 3'b010), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0);
        run_op("div", mk(F7M, 3'b100), 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1'b0);
        run_op("rem", mk(F7M, 3'b110), 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 1'b0);
        run_op("divu", mk(F7M, 3'b101), 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 33, 1'b0);
        run_op("remu", mk(F7M, 3'b111), 32'd100, 32'd7, 32'd2, 33, 1'b1);
        run_op("div0", mk(F7M, 3'b100), 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
        run_op("remu0", mk(F7M, 3'b111), 32'd5, 32'd0, 32'd5, 1, 1'b1);
        run_op("divovf", mk(F7M, 3'b100), 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
        run_op("removf", mk(F7M, 3'b110), 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1'b0);

        for (int k = 0; k < 3; k++) begin
            a = $urandom;
            b = $urandom;
            if (b == 32'd0) b = 32'd1;
            p = 64'(a) * 64'(b);
            run_op("rnd_mulhu", mk(F7M, 3'b011), a, b, p[63:32], 33, 1'b0);
            run_op("rnd_remu", mk(F7M, 3'b111), a, b, a % b, 33, 1'b0);
        end

        // Abort a divide by dropping valid at cycle 10
        @(negedge clk);
        insn = mk(F7M, 3'b100); rs1 = 32'd1000; rs2 = 32'd3; valid = 1'b1;
        repeat (10) @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        check_eq("abort:wait", 64'(wait_o), 64'(0));
        busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (rdy_o || wr_o || wait_o) busy++;
        end
        check_eq("abort:no_ready", 64'(busy), 64'(0));
        run_op("post_abort_mul", mk(F7M, 3'b000), 32'd3, 32'd4, 32'd12, 33, 1'b0);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        insn = mk(F7M, 3'b000); rs1 = 32'd9; rs2 = 32'd9; valid = 1'b1;
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check_eq("async_rst:wait", 64'(wait_o), 64'(0));
        check_eq("async_rst:ready", 64'(rdy_o), 64'(0));
        check_eq("async_rst:rd", 64'(rd_o), 64'(0));
        valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        run_op("post_rst_divu", mk(F7M, 3'b101), 32'd1000, 32'd3, 32'd333, 33, 1'b0);

        no_claim("f7_zero", mk(7'b0000000, 3'b000));

        sel = 1;
        run_op("u4_mul", mk(F7M, 3'b000), 32'd3, 32'd5, 32'd15, 9, 1'b0);
        run_op("u4_divu", mk(F7M, 3'b101), 32'd100, 32'd7, 32'd14, 9, 1'b0);
        run_op("u4_div", mk(F7M, 3'b100), 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 9, 1'b0);

        sel = 2;
        no_claim("nodiv_div", mk(F7M, 3'b100));
        run_op("nodiv_mul", mk(F7M, 3'b000), 32'd6, 32'd7, 32'd42, 33, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
